// File: rtl/fht_pkg.sv
// Shared FHT constants and the coefficient generator state type.
package fht_pkg;

   localparam int D_SIZE = 17;    // butterfly data width
   localparam int W_SIZE = 12;    // signed rotation coefficient width
   localparam int MAX_W  = 1024;  // coefficient full scale (unit amplitude)
   localparam int LOG2N  = 8;     // log2 of transform length

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } fht_state_e;

endpackage

// File: rtl/fht_sin_rom.sv
// Quarter-wave sine ROM, N/4+1 entries, two synchronous read ports that
// share one read enable. Contents are built at elaboration from the
// transform length so the table follows LOG2N.
module fht_sin_rom #(
   parameter int LOG2N  = 8,
   parameter int W_SIZE = 12,
   parameter int MAX_W  = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [LOG2N-2:0]     addr_a,
   input  logic [LOG2N-2:0]     addr_b,
   output logic [W_SIZE-1:0]    data_a,
   output logic [W_SIZE-1:0]    data_b
);

   localparam int Q = (1 << LOG2N) / 4;

   logic [W_SIZE-1:0] tbl [0:Q];

   // T[m] = round(MAX_W*sin(2*pi*m/N)); the last entry is pinned to full scale
   for (genvar m = 0; m <= Q; m++) begin : g_tbl
      localparam real ANG = 6.283185307179586 * m / (4.0 * Q);
      localparam int  V   = (m == Q) ? MAX_W : $rtoi(MAX_W * $sin(ANG) + 0.5);
      assign tbl[m] = W_SIZE'(V);
   end

   // both ports read under the shared enable so a stall freezes them together
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_a <= '0;
         data_b <= '0;
      end else if (en) begin
         data_a <= tbl[addr_a];
         data_b <= tbl[addr_b];
      end
   end

endmodule

// File: rtl/fht_coef_gen.sv
// FHT rotation coefficient generator: walks b = 0..N/2-1 for one stage and
// emits (sin, cos) of 2*pi*k/N with k = (b mod 2^s) << (LOG2N-1-s).
// Two-stage pipeline: counter/ROM address, then ROM + quadrant fold into the
// output register. Whole pipeline stalls while an output is held unaccepted.
module fht_coef_gen
   import fht_pkg::*;
#(
   parameter int LOG2N  = fht_pkg::LOG2N,
   parameter int W_SIZE = fht_pkg::W_SIZE,
   parameter int MAX_W  = fht_pkg::MAX_W
) (
   input  logic                     iCLK,
   input  logic                     iRESET,
   input  logic                     iSTART,
   input  logic [$clog2(LOG2N)-1:0] iSTAGE,
   input  logic                     iREADY,
   output logic [W_SIZE-1:0]        oSIN,
   output logic [W_SIZE-1:0]        oCOS,
   output logic [LOG2N-2:0]         oIDX,
   output logic                     oVALID,
   output logic                     oBUSY,
   output logic                     oDONE
);

   localparam int            AW     = LOG2N - 1;
   localparam int            SW     = $clog2(LOG2N);
   localparam int            Q      = (1 << LOG2N) / 4;
   localparam logic [AW-1:0] QA     = AW'(Q);
   localparam logic [AW-1:0] B_LAST = '1;

   fht_state_e        st;
   logic [SW-1:0]     stage;
   logic [AW-1:0]     cnt;
   logic              iss_done;
   logic              issue;
   logic [2:1]        vld_pipe;
   logic              en, xfer;
   logic [AW-1:0]     bmask, k, kp, addr_s, addr_c;
   logic              hi;
   logic              neg1;
   logic [AW-1:0]     idx1;
   logic [W_SIZE-1:0] rom_s, rom_c;

   assign issue  = (st == ST_RUN) && !iss_done;
   assign oVALID = vld_pipe[2];
   assign en     = !vld_pipe[2] || iREADY;
   assign xfer   = vld_pipe[2] && iREADY;
   assign oBUSY  = (st != ST_IDLE);
   assign oDONE  = (st == ST_DONE);

   // angle index and quadrant fold into the two quarter-wave addresses
   always_comb begin
      bmask  = AW'((1 << stage) - 1);
      k      = AW'((cnt & bmask) << (AW - int'(stage)));
      hi     = (k >= QA);
      kp     = k - QA;
      addr_s = hi ? QA - kp : k;
      addr_c = hi ? kp : QA - k;
   end

   // control FSM and butterfly counter; iSTART only matters in IDLE
   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         st       <= ST_IDLE;
         stage    <= '0;
         cnt      <= '0;
         iss_done <= 1'b0;
      end else begin
         case (st)
            ST_IDLE: if (iSTART) begin
               st       <= ST_RUN;
               stage    <= iSTAGE;
               cnt      <= '0;
               iss_done <= 1'b0;
            end
            ST_RUN: begin
               if (en && issue) begin
                  cnt <= cnt + 1'b1;
                  if (cnt == B_LAST) iss_done <= 1'b1;
               end
               if (xfer && oIDX == B_LAST) st <= ST_DONE;
            end
            default: st <= ST_IDLE;
         endcase
      end
   end

   // pipeline valids and sideband alongside the ROM read
   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         vld_pipe <= '0;
         neg1     <= 1'b0;
         idx1     <= '0;
      end else if (en) begin
         vld_pipe <= {vld_pipe[1], issue};
         neg1     <= hi;
         idx1     <= cnt;
      end
   end

   // output register; cos is negated in the second quadrant (-0 stays 0)
   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         oSIN <= '0;
         oCOS <= '0;
         oIDX <= '0;
      end else if (en && vld_pipe[1]) begin
         oSIN <= rom_s;
         oCOS <= neg1 ? -rom_c : rom_c;
         oIDX <= idx1;
      end
   end

   fht_sin_rom #(
      .LOG2N  (LOG2N),
      .W_SIZE (W_SIZE),
      .MAX_W  (MAX_W)
   ) u_rom (
      .clk    (iCLK),
      .rst    (iRESET),
      .en     (en),
      .addr_a (addr_s),
      .addr_b (addr_c),
      .data_a (rom_s),
      .data_b (rom_c)
   );

endmodule

// File: tb/tb_fht_coef_gen.sv
// Directed bench for fht_coef_gen: stage sweeps against a real-valued model,
// backpressure, ignored restart, and mid-run reset.
module tb_fht_coef_gen;

   localparam int  LOG2N  = 8;
   localparam int  N      = 1 << LOG2N;
   localparam int  W_SIZE = 12;
   localparam int  MAX_W  = 1024;
   localparam real PI     = 3.141592653589793;

   logic              iCLK = 1'b0;
   logic              iRESET;
   logic              iSTART;
   logic [2:0]        iSTAGE;
   logic              iREADY;
   logic [W_SIZE-1:0] oSIN, oCOS;
   logic [LOG2N-2:0]  oIDX;
   logic              oVALID, oBUSY, oDONE;

   int checks = 0;
   int errors = 0;

   fht_coef_gen #(.LOG2N(LOG2N), .W_SIZE(W_SIZE), .MAX_W(MAX_W)) dut (
      .iCLK   (iCLK),
      .iRESET (iRESET),
      .iSTART (iSTART),
      .iSTAGE (iSTAGE),
      .iREADY (iREADY),
      .oSIN   (oSIN),
      .oCOS   (oCOS),
      .oIDX   (oIDX),
      .oVALID (oVALID),
      .oBUSY  (oBUSY),
      .oDONE  (oDONE)
   );

   always #5 iCLK = ~iCLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d, expected %0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   task automatic chk_tol(input string tag, input int obs, input int exp, input int tol);
      checks++;
      assert (obs >= exp - tol && obs <= exp + tol) else begin
         errors++;
         $error("FAIL %s: observed %0d, expected %0d +/- %0d", tag, obs, exp, tol);
      end
   endtask

   // compare the current output pair against round(MAX_W*sin/cos) of the model angle
   task automatic check_pair(input int s, input int b);
      int  k, es, ec, os, oc;
      real ang;
      k   = (b % (1 << s)) << (LOG2N - 1 - s);
      ang = 2.0 * PI * k / N;
      es  = int'(MAX_W * $sin(ang));
      ec  = int'(MAX_W * $cos(ang));
      os  = int'($signed(oSIN));
      oc  = int'($signed(oCOS));
      chk_tol("sin", os, es, 1);
      chk_tol("cos", oc, ec, 1);
      chk_tol("pwr", os * os + oc * oc, MAX_W * MAX_W, MAX_W * MAX_W / 100);
      if (s == 0) begin
         chk("s0_sin", os, 0);
         chk("s0_cos", oc, 1024);
      end
      if (s == 7) begin
         case (b)
            0:  begin chk("s7_b0_cos", oc, 1024);  chk("s7_b0_sin", os, 0);    end
            32: begin chk("s7_b32_cos", oc, 724);  chk("s7_b32_sin", os, 724); end
            64: begin chk("s7_b64_cos", oc, 0);    chk("s7_b64_sin", os, 1024); end
            96: begin chk("s7_b96_cos", oc, -724); chk("s7_b96_sin", os, 724); end
            default: ;
         endcase
      end
   endtask

   // called just after a negedge; leaves us at the negedge where the first pair shows
   task automatic do_start(input int s);
      iSTART = 1'b1;
      iSTAGE = 3'(s);
      @(negedge iCLK);
      iSTART = 1'b0;
      chk("busy_after_start", oBUSY, 1);
      chk("no_valid_c1", oVALID, 0);
      @(negedge iCLK);
      chk("no_valid_c2", oVALID, 0);
      @(negedge iCLK);
      chk("first_valid", oVALID, 1);
      chk("first_idx", oIDX, 0);
   endtask

   // consume one stage; optional stall at stall_at, reset at rst_at, stray iSTART
   task automatic run(input int s, input int stall_at, input int rst_at, input bit inj);
      int nx = 0, stc = 0, cyc = 0, last_cyc = 0;
      bit fin = 0;
      iREADY = 1'b1;
      while (!fin) begin
         if (cyc >= 600) begin
            chk("timeout_done", oDONE, 1);
            fin = 1;
         end else if (oDONE) begin
            chk("done_count", nx, N / 2);
            chk("done_latency", cyc - last_cyc, 1);
            chk("done_valid", oVALID, 0);
            chk("done_busy", oBUSY, 1);
            fin = 1;
         end else if (oVALID) begin
            if (rst_at >= 0 && int'(oIDX) == rst_at) begin
               iRESET = 1'b1;
               #1;
               chk("rst_sin", oSIN, 0);
               chk("rst_cos", oCOS, 0);
               chk("rst_idx", oIDX, 0);
               chk("rst_valid", oVALID, 0);
               chk("rst_busy", oBUSY, 0);
               chk("rst_done", oDONE, 0);
               fin = 1;
            end else if (int'(oIDX) == stall_at && stc < 3) begin
               iREADY = 1'b0;
               stc++;
               chk("stall_idx", oIDX, stall_at);
               check_pair(s, stall_at);
            end else begin
               iREADY = 1'b1;
               chk("idx_seq", oIDX, nx);
               check_pair(s, nx);
               nx++;
               if (nx == N / 2) last_cyc = cyc;
            end
         end
         if (inj) begin
            iSTART = (cyc == 20);
            if (cyc == 20) iSTAGE = 3'd3;
         end
         if (!fin) begin
            @(negedge iCLK);
            cyc++;
         end
      end
      iSTART = 1'b0;
      iREADY = 1'b1;
   endtask

   task automatic post_done();
      @(negedge iCLK);
      chk("idle_busy", oBUSY, 0);
      chk("idle_done", oDONE, 0);
   endtask

   initial begin
      iRESET = 1'b1;
      iSTART = 1'b0;
      iSTAGE = '0;
      iREADY = 1'b1;
      repeat (3) @(negedge iCLK);
      chk("reset_sin", oSIN, 0);
      chk("reset_cos", oCOS, 0);
      chk("reset_idx", oIDX, 0);
      chk("reset_valid", oVALID, 0);
      chk("reset_busy", oBUSY, 0);
      chk("reset_done", oDONE, 0);

      // start on the very first edge after reset release
      iRESET = 1'b0;
      do_start(0); run(0, -1, -1, 0); post_done();
      do_start(7); run(7, -1, -1, 0); post_done();
      do_start(7); run(7, 10, -1, 0); post_done();
      do_start(5); run(5, -1, -1, 1); post_done();

      // reset mid-run, then a clean stage 2
      do_start(7); run(7, -1, 50, 0);
      @(negedge iCLK);
      iRESET = 1'b0;
      repeat (2) begin
         @(negedge iCLK);
         chk("post_rst_valid", oVALID, 0);
         chk("post_rst_done", oDONE, 0);
         chk("post_rst_busy", oBUSY, 0);
      end
      do_start(2); run(2, -1, -1, 0); post_done();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
